// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: request/response records and FSM states.
// Optional macro DMEM_ERR_CHECK_EN adds the err field and the request error check.
package dmem_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
`ifdef DMEM_ERR_CHECK_EN
        logic        err;
`endif
    } dmem_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S0   = 2'd1,
        S1   = 2'd2,
        RESP = 2'd3
    } dmem_state_t;

    // Misaligned full-word/half-word access, or address beyond the array.
    function automatic logic req_has_error(input logic [3:0] be, input logic [31:0] addr,
                                           input int unsigned addr_w);
        logic [31:0] upper;
        logic        misaligned;
        upper      = addr >> (addr_w + 2);
        misaligned = ((be == 4'hF) && (addr[1:0] != 2'b00)) ||
                     (((be == 4'h3) || (be == 4'hC)) && addr[0]);
        return misaligned || (upper != '0);
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port DEPTH x 32 SRAM with byte write enables and a registered read port.
// Contents are not reset; rdata only changes on a read access.
module dmem_sram #(
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Dual-lane load/store responder serialising lane 0 then lane 1 through one SRAM.
// Optional macro DMEM_ERR_CHECK_EN adds resp_err and blocks erroring accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_we,
    input  logic [1:0][3:0]  req_be,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    output logic             req_ready,
    output logic [1:0]       resp_valid,
    output logic [1:0][31:0] resp_rdata,
`ifdef DMEM_ERR_CHECK_EN
    output logic [1:0]       resp_err,
`endif
    output logic             busy
);

    dmem_state_t state, state_nxt;
    dmem_req_t   lane0_q, lane1_q, cur;
    logic [31:0] hold0_q;
    logic [1:0]  lane_err;
    logic        cur_err;
    logic        accept;

    logic              sram_en, sram_we;
    logic [ADDR_W-1:0] sram_idx;
    logic [31:0]       sram_rdata;

    dmem_resp_t resp0, resp1;

    assign accept = (state == IDLE) && (|req_valid);

`ifdef DMEM_ERR_CHECK_EN
    always_comb begin
        lane_err    = '0;
        lane_err[0] = req_has_error(lane0_q.be, lane0_q.addr, ADDR_W);
        lane_err[1] = req_has_error(lane1_q.be, lane1_q.addr, ADDR_W);
    end
`else
    logic unused_addr_bits;
    always_comb lane_err = '0;
    always_comb unused_addr_bits = ^{lane0_q.addr, lane1_q.addr};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lane0_q <= '0;
            lane1_q <= '0;
        end else if (accept) begin
            lane0_q <= '{valid: req_valid[0], we: req_we[0], be: req_be[0],
                         addr: req_addr[0], wdata: req_wdata[0]};
            lane1_q <= '{valid: req_valid[1], we: req_we[1], be: req_be[1],
                         addr: req_addr[1], wdata: req_wdata[1]};
        end
    end

    always_comb begin
        cur      = (state == S1) ? lane1_q : lane0_q;
        cur_err  = (state == S1) ? lane_err[1] : lane_err[0];
        sram_en  = (state == S0) || (state == S1);
        sram_we  = cur.we && !cur_err;
        sram_idx = cur.addr[ADDR_W+1:2];
    end

    dmem_sram #(.DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .be    (cur.be),
        .idx   (sram_idx),
        .wdata (cur.wdata),
        .rdata (sram_rdata)
    );

    // The SRAM read is registered, so the last lane's word is taken straight from
    // the SRAM output in RESP; only lane 0 needs parking when lane 1 follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold0_q <= '0;
        end else if (state == S1) begin
            hold0_q <= sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|req_valid) state_nxt = req_valid[0] ? S0 : S1;
            S0:      state_nxt = lane1_q.valid ? S1 : RESP;
            S1:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        resp0     = '0;
        resp1     = '0;
        req_ready = (state == IDLE);
        busy      = accept || (state == S0) || (state == S1);
        if (state == RESP) begin
            resp0.valid = lane0_q.valid;
            resp1.valid = lane1_q.valid;
            if (lane0_q.valid && !lane0_q.we && !lane_err[0]) begin
                resp0.rdata = lane1_q.valid ? hold0_q : sram_rdata;
            end
            if (lane1_q.valid && !lane1_q.we && !lane_err[1]) begin
                resp1.rdata = sram_rdata;
            end
`ifdef DMEM_ERR_CHECK_EN
            resp0.err = lane0_q.valid && lane_err[0];
            resp1.err = lane1_q.valid && lane_err[1];
`endif
        end
        resp_valid    = {resp1.valid, resp0.valid};
        resp_rdata[0] = resp0.rdata;
        resp_rdata[1] = resp1.rdata;
`ifdef DMEM_ERR_CHECK_EN
        resp_err      = {resp1.err, resp0.err};
`endif
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder plus a mid-transaction reset sequence.
// Expected data follows DMEM_ERR_CHECK_EN where the error check changes results.
module tb_dmem_responder;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_we;
    logic [1:0][3:0]  req_be;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic             req_ready;
    logic [1:0]       resp_valid;
    logic [1:0][31:0] resp_rdata;
    logic             busy;
`ifdef DMEM_ERR_CHECK_EN
    logic [1:0]       resp_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
`ifdef DMEM_ERR_CHECK_EN
        .resp_err   (resp_err),
`endif
        .busy       (busy)
    );

    typedef struct {
        string       name;
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [3:0]  be0, be1;
        logic [31:0] a0, a1, w0, w1;
        logic [1:0]  ev;
        logic [31:0] e0, e1;
        logic [1:0]  eerr;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        int  n;
        int  exp_n;
        bit  got;
        exp_n = int'(v.valid[0]) + int'(v.valid[1]) + 1;
        @(negedge clk);
        req_valid = v.valid;
        req_we    = v.we;
        req_be    = {v.be1, v.be0};
        req_addr  = {v.a1, v.a0};
        req_wdata = {v.w1, v.w0};
        #1;
        chk({v.name, "/ready_idle"}, 32'(req_ready), 32'd1);
        chk({v.name, "/busy_idle"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        // Request held valid but with other fields changed: responder must ignore them.
        req_we    = ~req_we;
        req_addr  = ~req_addr;
        req_wdata = ~req_wdata;
        n   = 0;
        got = 1'b0;
        while (!got && n < 6) begin
            @(negedge clk);
            n++;
            if (resp_valid != 2'b00) got = 1'b1;
            else chk({v.name, "/busy_wait"}, 32'(busy), 32'd1);
        end
        if (!got) begin
            chk({v.name, "/timeout"}, 32'(resp_valid), 32'(v.ev));
        end else begin
            chk({v.name, "/latency"}, 32'(n), 32'(exp_n));
            chk({v.name, "/resp_valid"}, 32'(resp_valid), 32'(v.ev));
            chk({v.name, "/rdata0"}, resp_rdata[0], v.e0);
            chk({v.name, "/rdata1"}, resp_rdata[1], v.e1);
            chk({v.name, "/busy_resp"}, 32'(busy), 32'd0);
            chk({v.name, "/ready_resp"}, 32'(req_ready), 32'd0);
`ifdef DMEM_ERR_CHECK_EN
            chk({v.name, "/resp_err"}, 32'(resp_err), 32'(v.eerr));
`endif
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk({v.name, "/pulse_end"}, 32'(resp_valid), 32'd0);
    endtask

    function automatic vec_t mk(input string name, input logic [1:0] valid, input logic [1:0] we,
                                input logic [3:0] be0, input logic [31:0] a0, input logic [31:0] w0,
                                input logic [3:0] be1, input logic [31:0] a1, input logic [31:0] w1,
                                input logic [1:0] ev, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eerr);
        vec_t v;
        v.name = name; v.valid = valid; v.we = we;
        v.be0 = be0; v.a0 = a0; v.w0 = w0;
        v.be1 = be1; v.a1 = a1; v.w1 = w1;
        v.ev = ev; v.e0 = e0; v.e1 = e1; v.eerr = eerr;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] wrap_data;
        logic [31:0] wrap_read0;
        logic [1:0]  wrap_err;
        bit          saw_resp;
`ifdef DMEM_ERR_CHECK_EN
        wrap_read0 = 32'h0000_0000;
        wrap_data  = 32'h0000_0000;
        wrap_err   = 2'b01;
`else
        wrap_read0 = 32'h0000_0055;
        wrap_data  = 32'hDEAD_BEEF;
        wrap_err   = 2'b00;
`endif
        //               name      valid  we     be0   a0          w0            be1   a1          w1            ev     e0            e1            eerr
        vecs[0]  = mk("init",     2'b11, 2'b11, 4'hF, 32'h00,     32'h0000_0000, 4'hF, 32'h20,     32'hFFFF_FFFF, 2'b11, 32'h0,        32'h0,        2'b00);
        vecs[1]  = mk("st_ld_haz",2'b11, 2'b01, 4'hF, 32'h10,     32'hDEAD_BEEF, 4'h0, 32'h10,     32'h0,         2'b11, 32'h0,        32'hDEAD_BEEF,2'b00);
        vecs[2]  = mk("st_l0",    2'b01, 2'b01, 4'hF, 32'h04,     32'h1234_5678, 4'h0, 32'h0,      32'h0,         2'b01, 32'h0,        32'h0,        2'b00);
        vecs[3]  = mk("ld_l1only",2'b10, 2'b01, 4'hF, 32'h10,     32'h0,         4'h0, 32'h04,     32'h0,         2'b10, 32'h0,        32'h1234_5678,2'b00);
        vecs[4]  = mk("byte_mrg", 2'b11, 2'b11, 4'h1, 32'h20,     32'h0000_00AA, 4'h2, 32'h20,     32'h0000_BB00, 2'b11, 32'h0,        32'h0,        2'b00);
        vecs[5]  = mk("ld_pair",  2'b11, 2'b00, 4'h0, 32'h20,     32'h0,         4'h0, 32'h10,     32'h0,         2'b11, 32'hFFFF_BBAA, 32'hDEAD_BEEF,2'b00);
        vecs[6]  = mk("overlap",  2'b11, 2'b11, 4'hF, 32'h30,     32'h1111_1111, 4'h6, 32'h30,     32'h2222_2222, 2'b11, 32'h0,        32'h0,        2'b00);
        vecs[7]  = mk("ld_l0only",2'b01, 2'b00, 4'h0, 32'h30,     32'h0,         4'h0, 32'h0,      32'h0,         2'b01, 32'h1122_2211, 32'h0,        2'b00);
        vecs[8]  = mk("be0_store",2'b11, 2'b01, 4'h0, 32'h30,     32'h0,         4'h0, 32'h33,     32'h0,         2'b11, 32'h0,        32'h1122_2211,2'b00);
        vecs[9]  = mk("wrap_st",  2'b01, 2'b01, 4'hF, 32'h1000,   32'h0000_0055, 4'h0, 32'h0,      32'h0,         2'b01, 32'h0,        32'h0,        wrap_err);
        vecs[10] = mk("wrap_ld0", 2'b01, 2'b00, 4'h0, 32'h00,     32'h0,         4'h0, 32'h0,      32'h0,         2'b01, wrap_read0,   32'h0,        2'b00);
        vecs[11] = mk("wrap_ld",  2'b11, 2'b00, 4'h0, 32'h1010,   32'h0,         4'h0, 32'h04,     32'h0,         2'b11, wrap_data,    32'h1234_5678,wrap_err);

        rst       = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_be    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/ready", 32'(req_ready), 32'd1);
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/resp_valid", 32'(resp_valid), 32'd0);
        chk("reset/rdata0", resp_rdata[0], 32'h0);
        chk("reset/rdata1", resp_rdata[1], 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
        end

        // Reset while lane 1 is being served: response dropped, lane 0 store kept.
        @(negedge clk);
        req_valid = 2'b11;
        req_we    = 2'b01;
        req_be    = {4'h0, 4'hF};
        req_addr  = {32'h40, 32'h40};
        req_wdata = {32'h0, 32'hCAFE_F00D};
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid/busy_s0", 32'(busy), 32'd1);
        @(negedge clk);
        chk("rst_mid/busy_s1", 32'(busy), 32'd1);
        rst       = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rst_mid/ready", 32'(req_ready), 32'd1);
        chk("rst_mid/resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid/busy", 32'(busy), 32'd0);
        rst = 1'b0;
        saw_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid != 2'b00) saw_resp = 1'b1;
        end
        chk("rst_mid/no_pulse", 32'(saw_resp), 32'd0);
        apply(mk("rst_persist", 2'b01, 2'b00, 4'h0, 32'h40, 32'h0, 4'h0, 32'h0, 32'h0,
                 2'b01, 32'hCAFE_F00D, 32'h0, 2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
